// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the multiply-accumulate stream unit.
package mac_pkg;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ACC  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StAcc  = ACC,
    StDone = DONE
  } mac_state_e;

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear and enable; cout_o flags the all-ones terminal count.
module counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         cout_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;
  assign cout_o  = &count_q;

endmodule

// File: rtl/mac_ctrl.sv
// Job-control FSM: start/len handshake, operand acceptance and the one-cycle done pulse.
module mac_ctrl
  import mac_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             in_valid_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             cnt_full_i,
  output logic             in_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             accept_o,
  output logic             clr_o
);

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    accept_o   = 1'b0;
    clr_o      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d   = len_i;
          clr_o   = 1'b1;
          state_d = (len_i == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        busy_o     = 1'b1;
        // The count never saturates inside a job; the guard keeps it from wrapping regardless.
        in_ready_o = ~cnt_full_i;
        if (in_valid_i && in_ready_o) begin
          accept_o = 1'b1;
          if ((count_i + CNT_W'(1)) == len_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/my_adder8.sv
// 8-bit wrapping adder; carry out is intentionally discarded.
module my_adder8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/my_multiplier.sv
// Unsigned combinational multiplier returning the full-width product.
module my_multiplier #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] prod_o
);

  assign prod_o = (2*W)'(a_i) * (2*W)'(b_i);

endmodule

// File: rtl/mac_stream_unit.sv
// Sequential multiply-accumulate over a stream of operand pairs, sum(a*b) mod 2^ACC_W.
module mac_stream_unit
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_out
);

  logic               accept, clr_cnt, cnt_full;
  logic [CNT_W-1:0]   count;
  logic [2*IN_W-1:0]  prod;
  logic [ACC_W-1:0]   prod_ext, sum;
  logic [ACC_W-1:0]   acc_q, acc_d;

  mac_ctrl u_ctrl (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .len_i      (len),
    .in_valid_i (in_valid),
    .count_i    (count),
    .cnt_full_i (cnt_full),
    .in_ready_o (in_ready),
    .busy_o     (busy),
    .done_o     (done),
    .accept_o   (accept),
    .clr_o      (clr_cnt)
  );

  my_multiplier #(
    .W (IN_W)
  ) u_mul (
    .a_i    (in_a),
    .b_i    (in_b),
    .prod_o (prod)
  );

  assign prod_ext = ACC_W'(prod);

  my_adder8 u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (sum)
  );

  counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i   (clk),
    .rst_i   (rst | clr_cnt),
    .en_i    (accept),
    .count_o (count),
    .cout_o  (cnt_full)
  );

  always_comb begin
    acc_d = acc_q;
    if (clr_cnt) begin
      acc_d = '0;
    end else if (accept) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;

endmodule

// File: tb/tb_mac_stream_unit.sv
// Directed self-checking bench for mac_stream_unit with hand-computed expected results.
module tb_mac_stream_unit;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [5:0] len;
  logic [3:0] in_a, in_b;
  logic       in_ready, busy, done;
  logic [7:0] acc_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_stream_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .acc_out  (acc_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [5:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; len = '0; in_a = '0; in_b = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_acc", acc_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_done", done, 0);

    // T1: basic, in_valid high already during the start cycle (must be ignored in IDLE)
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;
    start_job(6'd3);
    check_eq("t1_ready", in_ready, 1);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_acc0", acc_out, 0);
    feed(4'd3, 4'd5);
    check_eq("t1_acc1", acc_out, 15);
    feed(4'd2, 4'd4);
    check_eq("t1_acc2", acc_out, 23);
    check_eq("t1_nodone", done, 0);
    feed(4'd1, 4'd1);
    check_eq("t1_done", done, 1);
    check_eq("t1_acc", acc_out, 24);
    check_eq("t1_ready_off", in_ready, 0);
    tick();
    in_valid = 1'b0;
    check_eq("t1_done_pulse", done, 0);
    check_eq("t1_idle_busy", busy, 0);
    check_eq("t1_hold", acc_out, 24);

    // T2: wrap modulo 256
    start_job(6'd2);
    check_eq("t2_clear", acc_out, 0);
    feed(4'd15, 4'd15);
    check_eq("t2_acc1", acc_out, 225);
    feed(4'd15, 4'd15);
    in_valid = 1'b0;
    check_eq("t2_done", done, 1);
    check_eq("t2_acc", acc_out, 194);
    tick();

    // T3: gaps in in_valid
    start_job(6'd2);
    feed(4'd3, 4'd5);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_gap_acc", acc_out, 15);
      check_eq("t3_gap_ready", in_ready, 1);
      check_eq("t3_gap_done", done, 0);
    end
    feed(4'd2, 4'd4);
    in_valid = 1'b0;
    check_eq("t3_done", done, 1);
    check_eq("t3_acc", acc_out, 23);
    tick();

    // T4: zero length
    start_job(6'd0);
    check_eq("t4_done", done, 1);
    check_eq("t4_ready", in_ready, 0);
    check_eq("t4_acc", acc_out, 0);
    tick();
    check_eq("t4_done_pulse", done, 0);
    check_eq("t4_busy", busy, 0);

    // T5: start mid-job is ignored
    start_job(6'd3);
    feed(4'd1, 4'd2);
    check_eq("t5_acc1", acc_out, 2);
    start = 1'b1; len = 6'd5;
    feed(4'd3, 4'd3);
    start = 1'b0;
    check_eq("t5_acc2", acc_out, 11);
    feed(4'd2, 4'd2);
    in_valid = 1'b0;
    check_eq("t5_done", done, 1);
    check_eq("t5_acc", acc_out, 15);
    tick();

    // T5b: reset mid-job
    start_job(6'd4);
    feed(4'd1, 4'd1);
    feed(4'd1, 4'd1);
    check_eq("t5r_acc_pre", acc_out, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check_eq("t5r_busy", busy, 0);
    check_eq("t5r_ready", in_ready, 0);
    check_eq("t5r_acc", acc_out, 0);
    check_eq("t5r_done", done, 0);

    // T6: full count
    start_job(6'd63);
    for (int i = 0; i < 63; i++) begin
      feed(4'd1, 4'd1);
      if (i == 61) check_eq("t6_nodone_62", done, 0);
    end
    in_valid = 1'b0;
    check_eq("t6_done", done, 1);
    check_eq("t6_acc", acc_out, 63);
    check_eq("t6_cout", dut.u_cnt.cout_o, 1);
    tick();
    start_job(6'd1);
    check_eq("t6_cnt_cleared", dut.u_cnt.count_o, 0);
    feed(4'd2, 4'd3);
    in_valid = 1'b0;
    check_eq("t6_next_done", done, 1);
    check_eq("t6_next_acc", acc_out, 6);
    tick();
    check_eq("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
